cmd_uart_bridge: RTL and testbench

Sits between the UART transceiver and the command processor in the Knight's Tour robot.
- Receive side: assembles two received bytes (high first) into a 16-bit command and presents it with a ready flag.
- Transmit side: sends single-byte responses (e.g. positive ack 0xA5) back over the UART, with a one-deep pending slot.
- The bench `sendCommand` / `checkPositiveAck` tasks drive this block's UART interface.

---
 rtl/cmd_uart_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_cmd_uart_bridge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_uart_bridge.sv
// rtl/cmd_uart_bridge.sv - two-byte command assembler and single-byte response sender for the UART link
//
// Purpose:
//   RX side collects two UART bytes (high byte first) into a 16-bit command
//   with a registered ready flag. TX side launches single-byte responses to
//   the UART transmitter and holds one further response in a pending slot.
//   Build option CMD_BYTE_TIMEOUT_EN adds an inter-byte timeout of
//   TIMEOUT_CLKS cycles. Without it, the RX path waits for the low byte
//   indefinitely.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   rx_rdy        UART RX holds a byte (level)
//   rx_data       received byte
//   clr_rx_rdy    combinational byte-consumed strobe
//   cmd           assembled command {high, low}
//   cmd_rdy       command valid (registered)
//   clr_cmd_rdy   consumer acknowledge of cmd
//   send_resp     one-cycle request to transmit resp
//   resp          response byte
//   tx_trmt       one-cycle start pulse to UART TX
//   tx_data       byte being transmitted
//   tx_done       UART TX finished the current byte
//   overrun       sticky error flag, cleared only by rst

module cmd_uart_bridge #(
    parameter int TIMEOUT_CLKS = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        tx_trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        overrun
);

    typedef enum logic {WAIT_HI, WAIT_LO} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    rx_state_t   r_rx_state, w_rx_state_nxt;
    logic [7:0]  r_hi, w_hi_nxt;
    logic [15:0] r_cmd, w_cmd_nxt;
    logic        r_cmd_rdy, w_cmd_rdy_nxt;
    logic        w_ovr_rx;
    logic        w_timeout;

    tx_state_t   r_tx_state, w_tx_state_nxt;
    logic        r_tx_trmt, w_tx_trmt_nxt;
    logic [7:0]  r_tx_data, w_tx_data_nxt;
    logic        r_pend_full, w_pend_full_nxt;
    logic [7:0]  r_pend_data, w_pend_data_nxt;
    logic        w_ovr_tx;
    logic        w_done;

    logic        r_overrun;

`ifdef CMD_BYTE_TIMEOUT_EN
    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CLKS - 1);
    logic [23:0] r_to_cnt;

    // Held at zero outside WAIT_LO, so it starts from zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_to_cnt <= '0;
        else if (r_rx_state == WAIT_LO)
            r_to_cnt <= r_to_cnt + 24'd1;
        else
            r_to_cnt <= '0;
    end

    // A byte arriving on the terminal count wins over the timeout.
    assign w_timeout = (r_rx_state == WAIT_LO) && !rx_rdy && (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state  <= WAIT_HI;
            r_hi        <= '0;
            r_cmd       <= '0;
            r_cmd_rdy   <= 1'b0;
            r_tx_state  <= TX_IDLE;
            r_tx_trmt   <= 1'b0;
            r_tx_data   <= '0;
            r_pend_full <= 1'b0;
            r_pend_data <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_state_nxt;
            r_hi        <= w_hi_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cmd_rdy   <= w_cmd_rdy_nxt;
            r_tx_state  <= w_tx_state_nxt;
            r_tx_trmt   <= w_tx_trmt_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_pend_full <= w_pend_full_nxt;
            r_pend_data <= w_pend_data_nxt;
            r_overrun   <= r_overrun | w_ovr_rx | w_ovr_tx | w_timeout;
        end
    end

    // RX: every offered byte is consumed immediately, so clr_rx_rdy follows rx_rdy.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_hi_nxt       = r_hi;
        w_cmd_nxt      = r_cmd;
        w_cmd_rdy_nxt  = r_cmd_rdy;
        w_ovr_rx       = 1'b0;
        clr_rx_rdy     = 1'b0;
        case (r_rx_state)
            WAIT_HI: begin
                if (rx_rdy) begin
                    clr_rx_rdy     = 1'b1;
                    w_hi_nxt       = rx_data;
                    w_rx_state_nxt = WAIT_LO;
                end else if (clr_cmd_rdy) begin
                    w_cmd_rdy_nxt = 1'b0;
                end
            end
            WAIT_LO: begin
                if (rx_rdy) begin
                    clr_rx_rdy     = 1'b1;
                    w_rx_state_nxt = WAIT_HI;
                    // A same-cycle acknowledge frees the slot, and the new command takes it.
                    if (!r_cmd_rdy || clr_cmd_rdy) begin
                        w_cmd_nxt     = {r_hi, rx_data};
                        w_cmd_rdy_nxt = 1'b1;
                    end else begin
                        w_ovr_rx = 1'b1;
                    end
                end else begin
                    if (clr_cmd_rdy)
                        w_cmd_rdy_nxt = 1'b0;
                    if (w_timeout) begin
                        w_rx_state_nxt = WAIT_HI;
                        w_hi_nxt       = '0;
                    end
                end
            end
            default: w_rx_state_nxt = WAIT_HI;
        endcase
    end

    // tx_done is only meaningful in TX_BUSY once the start pulse has gone out.
    assign w_done = (r_tx_state == TX_BUSY) && tx_done && !r_tx_trmt;

    always_comb begin
        w_tx_state_nxt  = r_tx_state;
        w_tx_trmt_nxt   = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_pend_full_nxt = r_pend_full;
        w_pend_data_nxt = r_pend_data;
        w_ovr_tx        = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (send_resp) begin
                    w_tx_data_nxt  = resp;
                    w_tx_trmt_nxt  = 1'b1;
                    w_tx_state_nxt = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (w_done) begin
                    if (r_pend_full) begin
                        w_tx_data_nxt   = r_pend_data;
                        w_tx_trmt_nxt   = 1'b1;
                        // The slot drains this cycle, so a coincident request refills it.
                        w_pend_full_nxt = send_resp;
                        if (send_resp)
                            w_pend_data_nxt = resp;
                    end else if (send_resp) begin
                        w_tx_data_nxt = resp;
                        w_tx_trmt_nxt = 1'b1;
                    end else begin
                        w_tx_state_nxt = TX_IDLE;
                    end
                end else if (send_resp) begin
                    if (r_pend_full) begin
                        w_ovr_tx = 1'b1;
                    end else begin
                        w_pend_full_nxt = 1'b1;
                        w_pend_data_nxt = resp;
                    end
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;
    assign tx_trmt = r_tx_trmt;
    assign tx_data = r_tx_data;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_cmd_uart_bridge.sv
// tb/tb_cmd_uart_bridge.sv - self-checking bench for cmd_uart_bridge

module tb_cmd_uart_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = '0;
    logic        tx_trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        overrun;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    cmd_uart_bridge #(.TIMEOUT_CLKS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp  (send_resp),
        .resp       (resp),
        .tx_trmt    (tx_trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .overrun    (overrun)
    );

    typedef struct {
        logic        rst;
        logic        rx_rdy;
        logic [7:0]  rx_data;
        logic        clr_cmd;
        logic        send;
        logic [7:0]  resp;
        logic        done;
        logic        e_clr;
        logic [15:0] e_cmd;
        logic        e_rdy;
        logic        e_trmt;
        logic [7:0]  e_txd;
        logic        e_ovr;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic rr, input logic [7:0] rd,
                                input logic cc, input logic sr, input logic [7:0] rp,
                                input logic dn, input logic ec, input logic [15:0] ecmd,
                                input logic erdy, input logic etr, input logic [7:0] etxd,
                                input logic eov);
        vec_t v;
        v.rst = r; v.rx_rdy = rr; v.rx_data = rd; v.clr_cmd = cc; v.send = sr;
        v.resp = rp; v.done = dn; v.e_clr = ec; v.e_cmd = ecmd; v.e_rdy = erdy;
        v.e_trmt = etr; v.e_txd = etxd; v.e_ovr = eov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_rdy  = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_rdy  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " cmd"},     cmd, 16'h0000);
        chk({tag, " cmd_rdy"}, 16'(cmd_rdy), 16'd0);
        chk({tag, " tx_trmt"}, 16'(tx_trmt), 16'd0);
        chk({tag, " tx_data"}, 16'(tx_data), 16'h00);
        chk({tag, " overrun"}, 16'(overrun), 16'd0);
        chk({tag, " clr_rx"},  16'(clr_rx_rdy), 16'd0);
    endtask

    initial begin
        //            rst rx  data   clr snd resp   dn | clr cmd      rdy trm txd    ovr
        vecs[0]  = mk(0, 1, 8'h29, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 0, 8'h00, 0);
        vecs[1]  = mk(0, 1, 8'h00, 0, 0, 8'h00, 0,  1, 16'h2900, 1, 0, 8'h00, 0);
        vecs[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h2900, 1, 0, 8'h00, 0);
        vecs[3]  = mk(0, 1, 8'h4F, 0, 0, 8'h00, 0,  1, 16'h2900, 1, 0, 8'h00, 0);
        vecs[4]  = mk(0, 1, 8'hF1, 0, 0, 8'h00, 0,  1, 16'h2900, 1, 0, 8'h00, 1);
        vecs[5]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 0,  0, 16'h2900, 0, 0, 8'h00, 1);
        vecs[6]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 0, 0, 8'h00, 0);
        vecs[7]  = mk(0, 0, 8'h00, 0, 1, 8'hA5, 0,  0, 16'h0000, 0, 1, 8'hA5, 0);
        vecs[8]  = mk(0, 0, 8'h00, 0, 1, 8'h5A, 0,  0, 16'h0000, 0, 0, 8'hA5, 0);
        vecs[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 0, 0, 8'hA5, 0);
        vecs[10] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 16'h0000, 0, 1, 8'h5A, 0);
        vecs[11] = mk(0, 0, 8'h00, 0, 1, 8'h77, 0,  0, 16'h0000, 0, 0, 8'h5A, 0);
        vecs[12] = mk(0, 0, 8'h00, 0, 1, 8'h88, 0,  0, 16'h0000, 0, 0, 8'h5A, 1);
        vecs[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 16'h0000, 0, 1, 8'h77, 1);
        vecs[14] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 16'h0000, 0, 0, 8'h77, 1);
        vecs[15] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 16'h0000, 0, 0, 8'h77, 1);
        vecs[16] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 16'h0000, 0, 0, 8'h77, 1);
        vecs[17] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h0000, 0, 0, 8'h00, 0);
        vecs[18] = mk(0, 1, 8'h11, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 0, 8'h00, 0);
        vecs[19] = mk(0, 1, 8'h22, 0, 0, 8'h00, 0,  1, 16'h1122, 1, 0, 8'h00, 0);
        vecs[20] = mk(0, 1, 8'h33, 0, 0, 8'h00, 0,  1, 16'h1122, 1, 0, 8'h00, 0);
        vecs[21] = mk(0, 1, 8'h44, 1, 0, 8'h00, 0,  1, 16'h3344, 1, 0, 8'h00, 0);
        vecs[22] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0,  0, 16'h3344, 0, 0, 8'h00, 0);
        vecs[23] = mk(0, 0, 8'h00, 0, 1, 8'h3C, 0,  0, 16'h3344, 0, 1, 8'h3C, 0);
        vecs[24] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 16'h3344, 0, 0, 8'h3C, 0);
        vecs[25] = mk(0, 0, 8'h00, 0, 1, 8'hC3, 1,  0, 16'h3344, 0, 1, 8'hC3, 0);
        vecs[26] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 16'h3344, 0, 0, 8'hC3, 0);
        vecs[27] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 16'h3344, 0, 0, 8'hC3, 0);
        vecs[28] = mk(0, 1, 8'h55, 0, 1, 8'h99, 0,  1, 16'h3344, 0, 1, 8'h99, 0);
        vecs[29] = mk(0, 1, 8'h66, 0, 0, 8'h00, 0,  1, 16'h5566, 1, 0, 8'h99, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            rst         = vecs[i].rst;
            rx_rdy      = vecs[i].rx_rdy;
            rx_data     = vecs[i].rx_data;
            clr_cmd_rdy = vecs[i].clr_cmd;
            send_resp   = vecs[i].send;
            resp        = vecs[i].resp;
            tx_done     = vecs[i].done;
            #3;
            chk($sformatf("v%0d clr_rx_rdy", i), 16'(clr_rx_rdy), 16'(vecs[i].e_clr));
            @(posedge clk); #1;
            chk($sformatf("v%0d cmd", i),     cmd, vecs[i].e_cmd);
            chk($sformatf("v%0d cmd_rdy", i), 16'(cmd_rdy), 16'(vecs[i].e_rdy));
            chk($sformatf("v%0d tx_trmt", i), 16'(tx_trmt), 16'(vecs[i].e_trmt));
            chk($sformatf("v%0d tx_data", i), 16'(tx_data), 16'(vecs[i].e_txd));
            chk($sformatf("v%0d overrun", i), 16'(overrun), 16'(vecs[i].e_ovr));
        end
        rst = 1'b0; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; tx_done = 1'b0;

        // Reset mid-command and mid-transmit (TX is busy with 0x99 here)
        rx_rdy = 1'b1; rx_data = 8'h12; send_resp = 1'b1; resp = 8'hE2;
        @(posedge clk); #1;
        rx_rdy = 1'b0; send_resp = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        tx_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst%0d tx_trmt", k), 16'(tx_trmt), 16'd0);
        end
        tx_done = 1'b0;
        send_byte(8'h34);
        send_byte(8'h56);
        chk("post_rst cmd", cmd, 16'h3456);
        chk("post_rst cmd_rdy", 16'(cmd_rdy), 16'd1);
        chk("post_rst overrun", 16'(overrun), 16'd0);

        // Inter-byte gap of 20 clocks
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(8'h12);
        repeat (20) @(posedge clk);
        #1;
        send_byte(8'hAB);
        send_byte(8'hCD);
`ifdef CMD_BYTE_TIMEOUT_EN
        chk("gap cmd", cmd, 16'hABCD);
        chk("gap overrun", 16'(overrun), 16'd1);
`else
        chk("gap cmd", cmd, 16'h12AB);
        chk("gap overrun", 16'(overrun), 16'd0);
`endif
        chk("gap cmd_rdy", 16'(cmd_rdy), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
